// File: rtl/ifid_hazard_ctrl.sv
// rtl/ifid_hazard_ctrl.sv - PC / IF-ID / ID-EX hazard and sequencing controller
module ifid_hazard_ctrl #(
  parameter int REG_W        = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_MWAIT = 2'd2
  } state_t;

  localparam logic [2:0]       FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;      // state to resume once the memory freeze ends
  state_t           eff_state;         // state the current cycle behaves as
  logic [2:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu;
  logic             lost_cycle;

  // Load-use: the load in EX writes a register the ID instruction reads (r0 never hazards)
  always_comb begin
    lu = ex_mem_read && (ex_rd != '0) &&
         ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  end

  // The cycle that leaves MWAIT is evaluated as if already back in the saved state
  always_comb begin
    eff_state = (state_q == S_MWAIT) ? ret_q : state_q;
  end

  // Pipeline register controls, zero latency from current inputs
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (RST) begin
      pc_write    = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (mem_busy) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
    end else if (lu) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if ((eff_state == S_FLUSH) || branch_taken) begin
      ifid_flush  = 1'b1;
    end
  end

  // Next-state: freeze holds fcnt, load-use holds everything, flush counts down
  always_comb begin
    state_d = S_RUN;
    ret_d   = ret_q;
    fcnt_d  = fcnt_q;
    if (mem_busy) begin
      state_d = S_MWAIT;
      ret_d   = eff_state;
    end else if (lu) begin
      state_d = eff_state;
    end else if (eff_state == S_FLUSH) begin
      if (fcnt_q == 3'd1) begin
        state_d = S_RUN;
        fcnt_d  = 3'd0;
      end else begin
        state_d = S_FLUSH;
        fcnt_d  = fcnt_q - 3'd1;
      end
    end else if (branch_taken && (FLUSH_CYCLES > 1)) begin
      state_d = S_FLUSH;
      fcnt_d  = FLUSH_RELOAD;
    end
  end

  // Saturating lost-cycle counter
  always_comb begin
    lost_cycle = !pc_write || ifid_flush;
    cnt_d      = cnt_q;
    if (lost_cycle && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State registers; reset overrides all inputs so nothing unknown reaches state
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_RUN;
      ret_q   <= S_RUN;
      fcnt_q  <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      fcnt_q  <= fcnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// tb/tb_ifid_hazard_ctrl.sv - randomized and directed bench for ifid_hazard_ctrl
module tb_ifid_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int FC    = 2;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             CLK;
  logic             RST;
  logic [REG_W-1:0] id_rs, id_rt, ex_rd;
  logic             id_uses_rt, ex_mem_read, branch_taken, mem_busy;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [CNT_W-1:0] stall_count;

  int errors = 0;
  int checks = 0;

  // reference model: remaining forced flush cycles and lost-cycle count
  int m_flush_left = 0;
  int m_cnt        = 0;

  ifid_hazard_ctrl #(.REG_W(REG_W), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .stall_count(stall_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // one clock: drive, check combinational controls, clock, check counter
  task automatic cycle(input logic rst, input int rs, input int rt, input logic urt,
                       input logic mr, input int rd, input logic br, input logic busy);
    logic lu_m;
    int   e_pc, e_ifw, e_fl, e_bub;
    RST          = rst;
    id_rs        = REG_W'(rs);
    id_rt        = REG_W'(rt);
    id_uses_rt   = urt;
    ex_mem_read  = mr;
    ex_rd        = REG_W'(rd);
    branch_taken = br;
    mem_busy     = busy;
    #2;
    lu_m = mr && (rd != 0) && ((rd == rs) || (urt && (rd == rt)));
    if (rst)                            begin e_pc = 0; e_ifw = 1; e_fl = 1; e_bub = 1; end
    else if (busy)                      begin e_pc = 0; e_ifw = 0; e_fl = 0; e_bub = 0; end
    else if (lu_m)                      begin e_pc = 0; e_ifw = 0; e_fl = 0; e_bub = 1; end
    else if (m_flush_left > 0 || br)    begin e_pc = 1; e_ifw = 1; e_fl = 1; e_bub = 0; end
    else                                begin e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; end
    check("pc_write",    int'(pc_write),    e_pc);
    check("ifid_write",  int'(ifid_write),  e_ifw);
    check("ifid_flush",  int'(ifid_flush),  e_fl);
    check("idex_bubble", int'(idex_bubble), e_bub);
    @(posedge CLK);
    if (rst) begin
      m_flush_left = 0;
      m_cnt        = 0;
    end else begin
      if ((e_pc == 0 || e_fl == 1) && m_cnt < CMAX) m_cnt++;
      if (busy || lu_m) begin
      end else if (m_flush_left > 0) begin
        m_flush_left--;
      end else if (br) begin
        m_flush_left = FC - 1;
      end
    end
    #1;
    check("stall_count", int'(stall_count), m_cnt);
  endtask

  task automatic idle();
    cycle(1'b0, 1, 2, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    cycle(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // reset mid-flush
    cycle(1'b0, 1, 2, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    repeat (3) cycle(1'b1, 9, 9, 1'b1, 1'b1, 9, 1'b1, 1'b0);
    idle();
    check("rst_cnt", int'(stall_count), 0);

    // load-use on rs, then r0 destination
    cycle(1'b0, 5, 2, 1'b0, 1'b1, 5, 1'b0, 1'b0);
    idle();
    check("lu_cnt", int'(stall_count), 1);
    cycle(1'b0, 0, 2, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    check("r0_cnt", int'(stall_count), 1);

    // rt hazard gated by id_uses_rt
    cycle(1'b0, 1, 7, 1'b0, 1'b1, 7, 1'b0, 1'b0);
    cycle(1'b0, 1, 7, 1'b1, 1'b1, 7, 1'b0, 1'b0);
    idle();
    check("rt_cnt", int'(stall_count), 2);

    // branch flush, second branch during flush ignored
    cycle(1'b0, 1, 2, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    cycle(1'b0, 1, 2, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    idle();
    check("br_cnt", int'(stall_count), 4);

    // load-use masks branch; branch re-asserted flushes
    cycle(1'b0, 3, 2, 1'b0, 1'b1, 3, 1'b1, 1'b0);
    cycle(1'b0, 3, 2, 1'b0, 1'b0, 3, 1'b1, 1'b0);
    cycle(1'b0, 1, 2, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    idle();
    check("sim_cnt", int'(stall_count), 7);

    // memory freeze mid-flush, then saturation
    cycle(1'b0, 1, 2, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    repeat (4) cycle(1'b0, 1, 2, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    idle();
    idle();
    check("mw_cnt", int'(stall_count), 13);
    repeat (3) cycle(1'b0, 4, 2, 1'b0, 1'b1, 4, 1'b0, 1'b0);
    check("sat_cnt", int'(stall_count), CMAX);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) == 0),
            $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 7),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
